wb_stage: RTL and testbench

- Write-back stage of the 5-stage RISC-V pipeline, holding the MEM/WB pipeline register.
- Produces the register-file write port (Ctl_RegWrite_out, WriteReg, WriteData) that feeds the decode stage.
- Selects between ALU result, aligned/extended load data and PC+4.
- Suppresses writes to x0 and to faulting loads, and counts retired instructions.

---
 rtl/wb_stage.sv | 141 ++++++++++++++
 tb/tb_wb_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load alignment/extension, write-data select,
// x0/misaligned write suppression and retired-instruction counter. Optional WB_FWD_EN adds forwarding taps.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  Ctl_RegWrite_in,
    input  logic [1:0]            Ctl_MemtoReg_in,
    input  logic [2:0]            funct3_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [XLEN-1:0]       ALU_result_in,
    input  logic [XLEN-1:0]       ReadData_in,
    input  logic [XLEN-1:0]       PC_in,
    output logic                  Ctl_RegWrite_out,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [XLEN-1:0]       WriteData,
    output logic                  misaligned,
    output logic [31:0]           retire_count
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [XLEN-1:0]       fwd_data
`endif
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_NONE = 2'b11
    } wb_sel_e;

    logic                  valid_q;
    logic                  regwrite_q;
    logic [1:0]            memtoreg_q;
    logic [2:0]            funct3_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       rdata_q;
    logic [XLEN-1:0]       pc_q;
    logic [31:0]           retire_q;

    // An instruction retires when it leaves WB: either replaced (no stall) or killed by flush.
    logic retire_now;
    assign retire_now = valid_q & (~stall | flush);

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 2'b00;
            funct3_q   <= 3'b000;
            rd_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc_q       <= '0;
            retire_q   <= 32'd0;
        end else begin
            if (retire_now)
                retire_q <= retire_q + 32'd1;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q    <= valid_in;
                regwrite_q <= Ctl_RegWrite_in;
                memtoreg_q <= Ctl_MemtoReg_in;
                funct3_q   <= funct3_in;
                rd_q       <= rd_in;
                alu_q      <= ALU_result_in;
                rdata_q    <= ReadData_in;
                pc_q       <= PC_in;
            end
        end
    end

    logic [1:0]      off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            mis_cond;
    logic [XLEN-1:0] wb_mux;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        off       = alu_q[1:0];
        byte_sel  = rdata_q[7:0];
        half_sel  = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_data = rdata_q;
        mis_cond  = 1'b0;

        case (off)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase

        case (funct3_q)
            3'b000: load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: begin
                load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                mis_cond  = off[0];
            end
            3'b101: begin
                load_data = {{(XLEN-16){1'b0}}, half_sel};
                mis_cond  = off[0];
            end
            default: begin
                load_data = rdata_q;
                mis_cond  = (off != 2'b00);
            end
        endcase

        case (wb_sel_e'(memtoreg_q))
            SEL_ALU:  wb_mux = alu_q;
            SEL_LOAD: wb_mux = load_data;
            SEL_LINK: wb_mux = pc_q + XLEN'(4);
            default:  wb_mux = '0;
        endcase
    end

    // Outputs are qualified by valid_q so a bubble presents an all-zero write port.
    assign misaligned       = valid_q & (memtoreg_q == SEL_LOAD) & mis_cond;
    assign WriteData        = valid_q ? wb_mux : '0;
    assign WriteReg         = valid_q ? rd_q : '0;
    assign Ctl_RegWrite_out = valid_q & regwrite_q & (rd_q != '0) & ~misaligned;
    assign retire_count     = retire_q;

`ifdef WB_FWD_EN
    assign fwd_valid = Ctl_RegWrite_out;
    assign fwd_data  = WriteData;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven vectors plus stall/flush/reset/wrap sequences,
// expected results queued at drive time and compared one edge later.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam logic [31:0] W = 32'h80FF_7F01;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic            Ctl_RegWrite_in = 1'b0;
    logic [1:0]      Ctl_MemtoReg_in = 2'b00;
    logic [2:0]      funct3_in = 3'b000;
    logic [RW-1:0]   rd_in = '0;
    logic [XLEN-1:0] ALU_result_in = '0, ReadData_in = '0, PC_in = '0;
    logic            Ctl_RegWrite_out;
    logic [RW-1:0]   WriteReg;
    logic [XLEN-1:0] WriteData;
    logic            misaligned;
    logic [31:0]     retire_count;
`ifdef WB_FWD_EN
    logic            fwd_valid;
    logic [XLEN-1:0] fwd_data;
`endif

    wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .Ctl_RegWrite_in(Ctl_RegWrite_in), .Ctl_MemtoReg_in(Ctl_MemtoReg_in),
        .funct3_in(funct3_in), .rd_in(rd_in), .ALU_result_in(ALU_result_in),
        .ReadData_in(ReadData_in), .PC_in(PC_in),
        .Ctl_RegWrite_out(Ctl_RegWrite_out), .WriteReg(WriteReg), .WriteData(WriteData),
        .misaligned(misaligned), .retire_count(retire_count)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, vin, st, fl, rw;
        logic [1:0]    m2r;
        logic [2:0]    f3;
        logic [RW-1:0] rd;
        logic [31:0]   alu, rdat, pc;
        logic          ewe;
        logic [RW-1:0] ewreg;
        logic [31:0]   ewdata;
        logic          emis;
    } vec_t;

    typedef struct {
        string         name;
        logic          we;
        logic [RW-1:0] wreg;
        logic [31:0]   wdata;
        logic          mis;
        logic [31:0]   cnt;
    } exp_t;

    exp_t  exp_q[$];
    vec_t  tbl[];
    int    checks = 0;
    int    failures = 0;
    logic  model_valid = 1'b0;
    logic [31:0] model_cnt = 32'd0;

    function automatic vec_t mk(input logic rst, vin, st, fl, rw, input logic [1:0] m2r,
                                input logic [2:0] f3, input logic [RW-1:0] rd,
                                input logic [31:0] alu, rdat, pc,
                                input logic ewe, input logic [RW-1:0] ewreg,
                                input logic [31:0] ewdata, input logic emis);
        vec_t v;
        v.rst = rst; v.vin = vin; v.st = st; v.fl = fl; v.rw = rw; v.m2r = m2r; v.f3 = f3;
        v.rd = rd; v.alu = alu; v.rdat = rdat; v.pc = pc;
        v.ewe = ewe; v.ewreg = ewreg; v.ewdata = ewdata; v.emis = emis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector before the edge, queue its expectation, compare just after the edge.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; valid_in = v.vin; stall = v.st; flush = v.fl;
        Ctl_RegWrite_in = v.rw; Ctl_MemtoReg_in = v.m2r; funct3_in = v.f3; rd_in = v.rd;
        ALU_result_in = v.alu; ReadData_in = v.rdat; PC_in = v.pc;
        if (!v.rst) begin
            model_valid = 1'b0;
            model_cnt   = 32'd0;
        end else begin
            if (model_valid && (!v.st || v.fl)) model_cnt = model_cnt + 32'd1;
            if (v.fl) model_valid = 1'b0;
            else if (!v.st) model_valid = v.vin;
        end
        e.name = name; e.we = v.ewe; e.wreg = v.ewreg; e.wdata = v.ewdata;
        e.mis = v.emis; e.cnt = model_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.name, ".we"},    32'(Ctl_RegWrite_out), 32'(e.we));
        check({e.name, ".wreg"},  32'(WriteReg),         32'(e.wreg));
        check({e.name, ".wdata"}, WriteData,             e.wdata);
        check({e.name, ".mis"},   32'(misaligned),       32'(e.mis));
        check({e.name, ".cnt"},   retire_count,          e.cnt);
`ifdef WB_FWD_EN
        check({e.name, ".fwd_valid"}, 32'(fwd_valid), 32'(e.we));
        check({e.name, ".fwd_data"},  fwd_data,       e.wdata);
`endif
    endtask

    function automatic vec_t rnd(input logic rst, input logic vin);
        return mk(rst, vin, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                  3'($urandom), RW'($urandom), $urandom, $urandom, $urandom,
                  1'b0, '0, 32'd0, 1'b0);
    endfunction

    initial begin
        tbl = new[20];
        //          rst vin st fl rw m2r    f3      rd  alu           rdat pc             we wreg wdata          mis
        tbl[0]  = mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 10, 32'h3,        0, 32'h100,       1, 10, 32'h0000_0003, 0);
        tbl[1]  = mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 0,  32'h5,        0, 32'h100,       0, 0,  32'h0000_0005, 0);
        tbl[2]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b000, 5,  32'h1000,     W, 32'h100,       1, 5,  32'h0000_0001, 0);
        tbl[3]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b000, 5,  32'h1003,     W, 32'h100,       1, 5,  32'hFFFF_FF80, 0);
        tbl[4]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b000, 5,  32'h1001,     W, 32'h100,       1, 5,  32'h0000_007F, 0);
        tbl[5]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b100, 5,  32'h1002,     W, 32'h100,       1, 5,  32'h0000_00FF, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b100, 5,  32'h1003,     W, 32'h100,       1, 5,  32'h0000_0080, 0);
        tbl[7]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b001, 5,  32'h1002,     W, 32'h100,       1, 5,  32'hFFFF_80FF, 0);
        tbl[8]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b101, 5,  32'h1000,     W, 32'h100,       1, 5,  32'h0000_7F01, 0);
        tbl[9]  = mk(1, 1, 0, 0, 1, 2'b01, 3'b101, 5,  32'h1002,     W, 32'h100,       1, 5,  32'h0000_80FF, 0);
        tbl[10] = mk(1, 1, 0, 0, 1, 2'b01, 3'b010, 5,  32'h1001,     W, 32'h100,       0, 5,  W,             1);
        tbl[11] = mk(1, 1, 0, 0, 1, 2'b01, 3'b001, 5,  32'h1001,     W, 32'h100,       0, 5,  32'h0000_7F01, 1);
        tbl[12] = mk(1, 1, 0, 0, 1, 2'b01, 3'b011, 5,  32'h1000,     W, 32'h100,       1, 5,  W,             0);
        tbl[13] = mk(1, 1, 0, 0, 1, 2'b01, 3'b110, 5,  32'h1002,     W, 32'h100,       0, 5,  W,             1);
        tbl[14] = mk(1, 1, 0, 0, 1, 2'b10, 3'b000, 1,  32'h40,       W, 32'h14,        1, 1,  32'h0000_0018, 0);
        tbl[15] = mk(1, 1, 0, 0, 1, 2'b10, 3'b000, 1,  32'h40,       W, 32'hFFFF_FFFC, 1, 1,  32'h0000_0000, 0);
        tbl[16] = mk(1, 1, 0, 0, 1, 2'b11, 3'b000, 3,  32'h77,       W, 32'h100,       1, 3,  32'h0000_0000, 0);
        tbl[17] = mk(1, 1, 0, 0, 0, 2'b00, 3'b000, 4,  32'h9,        W, 32'h100,       0, 4,  32'h0000_0009, 0);
        tbl[18] = mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 4,  32'h9,        W, 32'h100,       0, 0,  32'h0000_0000, 0);
        tbl[19] = mk(1, 1, 0, 0, 1, 2'b00, 3'b010, 6,  32'h1001,     W, 32'h100,       1, 6,  32'h0000_1001, 0);

        // Reset held with random inputs, then released with no valid instruction.
        for (int i = 0; i < 2; i++) step($sformatf("rst%0d", i), rnd(1'b0, 1'b1));
        for (int i = 0; i < 2; i++) begin
            vec_t v;
            v = rnd(1'b1, 1'b0);
            v.st = 1'b0;
            v.fl = 1'b0;
            step($sformatf("idle%0d", i), v);
        end

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Stall holds instruction A for three cycles; it retires once when released.
        step("stallA",  mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 7, 32'h1234, 0, 32'h200, 1, 7, 32'h1234, 0));
        for (int i = 0; i < 3; i++)
            step($sformatf("hold%0d", i),
                 mk(1, 1, 1, 0, 1, 2'b00, 3'b000, 9, 32'hBEEF, 0, 32'h204, 1, 7, 32'h1234, 0));
        step("unstall", mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 9, 32'hBEEF, 0, 32'h204, 0, 0, 32'h0, 0));

        // Stall and flush together: flush wins and B retires on its way out.
        step("capB",    mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 8, 32'h55, 0, 32'h300, 1, 8, 32'h55, 0));
        step("stflush", mk(1, 1, 1, 1, 1, 2'b00, 3'b000, 9, 32'h66, 0, 32'h304, 0, 0, 32'h0, 0));
        step("flush",   mk(1, 1, 0, 1, 1, 2'b00, 3'b000, 9, 32'h66, 0, 32'h304, 0, 0, 32'h0, 0));

        // Reset arriving during a stall clears everything including the counter.
        step("capC",    mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 2, 32'h77, 0, 32'h400, 1, 2, 32'h77, 0));
        step("stallC",  mk(1, 1, 1, 0, 1, 2'b00, 3'b000, 3, 32'h88, 0, 32'h404, 1, 2, 32'h77, 0));
        step("rstmid",  mk(0, 1, 1, 0, 1, 2'b00, 3'b000, 3, 32'h88, 0, 32'h404, 0, 0, 32'h0, 0));

        // Counter wrap: preload all-ones, then retire one instruction.
        step("capD",    mk(1, 1, 0, 0, 1, 2'b00, 3'b000, 11, 32'hAA, 0, 32'h500, 1, 11, 32'hAA, 0));
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        model_cnt = 32'hFFFF_FFFF;
        check("preload.cnt", retire_count, 32'hFFFF_FFFF);
        step("wrap",    mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 11, 32'hAA, 0, 32'h500, 0, 0, 32'h0, 0));

        if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
